cdp_wdma_dma_req: RTL and testbench
===================================

CDP_WDMA_DMA_REQ -- requirements
Module: cdp_wdma_dma_req

Interface
REQ-001 Parameter: DW, 64, data beat width in bits; beat size in bytes is DW/8.
REQ-002 Parameter: SZW, 13, width of the beat-count field in the command.
REQ-003 Ports: one clock; reset is synchronous and active-high. Clock port nvdla_core_clk, reset port nvdla_core_rst.
REQ-004 nvdla_core_clk  in  1  core clock; all state updates on its rising edge.
REQ-005 nvdla_core_rst  in  1  synchronous active-high reset.
REQ-006 op_en  in  1  layer-start pulse; loads the base address.
REQ-007 reg2dp_dst_base_addr  in  32  destination base byte address.
REQ-008 reg2dp_dst_line_stride  in  32  byte stride between line starts.
REQ-009 cmd_fifo_rd_pvld  in  1  command valid from the WDMA command FIFO.
REQ-010 cmd_fifo_rd_prdy  out  1  command pop.
REQ-011 cmd_fifo_rd_pd  in  15  command: [12:0] beats-1, [13] line_end, [14] cube_end.
REQ-012 dat_pvld  in  1  write-data valid.
REQ-013 dat_prdy  out  1  write-data ready.
REQ-014 dat_pd  in  DW  write data.
REQ-015 dma_wr_req_pvld  out  1  DMA write request valid.
REQ-016 dma_wr_req_prdy  in  1  DMA write request ready.
REQ-017 dma_wr_req_type  out  1  0 = command beat, 1 = data beat.
REQ-018 dma_wr_req_pd  out  DW  command beat or data beat payload.
REQ-019 layer_done  out  1  one-cycle pulse after the last beat of a cube_end command.

Function
REQ-020 The FSM SHALL have the states IDLE, CMD and DATA.
REQ-021 IDLE: if op_en=1, cur_addr and line_addr SHALL load reg2dp_dst_base_addr, and cmd_fifo_rd_prdy SHALL be 0 in that cycle (op_en has priority).
REQ-022 IDLE: if op_en=0, cmd_fifo_rd_prdy SHALL be 1; when cmd_fifo_rd_pvld=1, the block SHALL latch size, line_end and cube_end and go to CMD.
REQ-023 cmd_fifo_rd_prdy SHALL be 0 in CMD and DATA.
REQ-024 CMD: dma_wr_req_pvld SHALL be 1 and dma_wr_req_type SHALL be 0.
REQ-025 CMD payload: pd[31:0] = cur_addr, pd[44:32] = size, pd[45] = cube_end, other bits 0.
REQ-026 CMD: on dma_wr_req_prdy=1, the FSM SHALL go to DATA with beat_cnt=0.
REQ-027 DATA: dma_wr_req_pvld = dat_pvld, dat_prdy = dma_wr_req_prdy, type = 1, pd = dat_pd (combinational pass-through, no storage).
REQ-028 dat_prdy SHALL be 0 outside DATA.
REQ-029 DATA: each accepted beat (dat_pvld & dma_wr_req_prdy) SHALL increment beat_cnt (SZW bits).
REQ-030 DATA: the accepted beat with beat_cnt==size SHALL end the command, and the FSM SHALL return to IDLE.
REQ-031 At command end with line_end=1: line_addr and cur_addr SHALL both become line_addr+stride.
REQ-032 At command end with line_end=0: cur_addr SHALL become cur_addr + (size+1)*DW/8.
REQ-033 All address arithmetic SHALL be mod 2^32 (wrap, no error).
REQ-034 At command end with cube_end=1: layer_done SHALL be 1 for exactly the next cycle.
REQ-035 Latency: a command popped at cycle N SHALL present its command beat at cycle N+1; the minimum command occupancy is size+3 cycles including the IDLE pop.
REQ-036 size=0 SHALL produce one command beat followed by exactly one data beat.
REQ-037 op_en outside IDLE SHALL be ignored.
REQ-038 Backpressure in CMD SHALL hold pvld, type and pd stable until accepted.

Reset
REQ-039 On nvdla_core_rst=1 at a clock edge, the block SHALL enter IDLE and clear cur_addr, line_addr, beat_cnt and the latched command to 0.
REQ-040 In the reset cycle and the cycle after, dma_wr_req_pvld, cmd_fifo_rd_prdy, dat_prdy and layer_done SHALL be 0 (outputs gated by reset).
REQ-041 Reset mid-command SHALL discard the partial command; beats already issued are not replayed and no layer_done is produced.

Verification
REQ-042 base=0x1000, op_en; cmd {size=3, line_end=0, cube_end=0}; prdy=1 -> command beat addr 0x1000 size 3, 4 data beats, next addr 0x1020.
REQ-043 base=0x1000, stride=0x400; two commands size=1 with line_end=1 -> command beat addrs 0x1000 then 0x1400.
REQ-044 cmd size=0 with cube_end=1 -> command beat pd[45]=1, one data beat, layer_done high for exactly 1 cycle after that beat.
REQ-045 dma_wr_req_prdy=0 for 5 cycles in CMD, then random data/prdy stalls in DATA -> payload stable while stalled, no beat lost or duplicated, count exact.
REQ-046 base=0xFFFFFFF0, size=3, line_end=0 -> next cur_addr 0x00000010 (wrap).
REQ-047 Reset asserted after 2 of 4 data beats -> IDLE, all outputs 0, no layer_done; a following op_en with base=0x2000 restarts at 0x2000.

Source files
------------

// File: rtl/cdp_wdma_dma_req_if.sv
// WDMA request-side bundle: command FIFO read, write-data stream and DMA write request port.
// Slave modport is the request block's view; master is the environment's view.
interface cdp_wdma_dma_req_if #(
    parameter int DW  = 64,
    parameter int SZW = 13
);
    logic               cmd_fifo_rd_pvld;
    logic               cmd_fifo_rd_prdy;
    logic [SZW+1:0]     cmd_fifo_rd_pd;
    logic               dat_pvld;
    logic               dat_prdy;
    logic [DW-1:0]      dat_pd;
    logic               dma_wr_req_pvld;
    logic               dma_wr_req_prdy;
    logic               dma_wr_req_type;
    logic [DW-1:0]      dma_wr_req_pd;

    modport slave (
        input  cmd_fifo_rd_pvld, cmd_fifo_rd_pd, dat_pvld, dat_pd, dma_wr_req_prdy,
        output cmd_fifo_rd_prdy, dat_prdy, dma_wr_req_pvld, dma_wr_req_type, dma_wr_req_pd
    );

    modport master (
        output cmd_fifo_rd_pvld, cmd_fifo_rd_pd, dat_pvld, dat_pd, dma_wr_req_prdy,
        input  cmd_fifo_rd_prdy, dat_prdy, dma_wr_req_pvld, dma_wr_req_type, dma_wr_req_pd
    );
endinterface

// File: rtl/cdp_wdma_dma_req.sv
// Turns WDMA commands into a DMA command beat followed by size+1 pass-through data beats.
// Command beat one cycle after pop; data is combinational; DMA backpressure stalls both.
module cdp_wdma_dma_req #(
    parameter int DW  = 64,
    parameter int SZW = 13
) (
    input  logic        nvdla_core_clk,
    input  logic        nvdla_core_rst,
    input  logic        op_en,
    input  logic [31:0] reg2dp_dst_base_addr,
    input  logic [31:0] reg2dp_dst_line_stride,
    output logic        layer_done,
    cdp_wdma_dma_req_if.slave bus
);
    localparam logic [31:0] BEAT_BYTES = 32'(DW / 8);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t         state_q, state_d;
    logic [31:0]    cur_addr_q, cur_addr_d;
    logic [31:0]    line_addr_q, line_addr_d;
    logic [SZW-1:0] beat_cnt_q, beat_cnt_d;
    logic [SZW-1:0] size_q, size_d;
    logic           line_end_q, line_end_d;
    logic           cube_end_q, cube_end_d;
    logic           layer_done_q, layer_done_d;
    logic           rst_q;
    logic           out_gate;

    logic           cmd_prdy_c, dat_prdy_c, req_pvld_c, req_type_c;
    logic [DW-1:0]  req_pd_c, cmd_pd;

    // Outputs stay quiet in the reset cycle and the one after it.
    assign out_gate              = nvdla_core_rst | rst_q;
    assign bus.cmd_fifo_rd_prdy  = cmd_prdy_c & ~out_gate;
    assign bus.dat_prdy          = dat_prdy_c & ~out_gate;
    assign bus.dma_wr_req_pvld   = req_pvld_c & ~out_gate;
    assign bus.dma_wr_req_type   = req_type_c;
    assign bus.dma_wr_req_pd     = req_pd_c;
    assign layer_done            = layer_done_q & ~out_gate;

    always_comb begin
        cmd_pd                  = '0;
        cmd_pd[31:0]            = cur_addr_q;
        cmd_pd[32 +: SZW]       = size_q;
        cmd_pd[32 + SZW]        = cube_end_q;
    end

    always_ff @(posedge nvdla_core_clk) begin
        rst_q <= nvdla_core_rst;
        if (nvdla_core_rst) begin
            state_q      <= IDLE;
            cur_addr_q   <= '0;
            line_addr_q  <= '0;
            beat_cnt_q   <= '0;
            size_q       <= '0;
            line_end_q   <= 1'b0;
            cube_end_q   <= 1'b0;
            layer_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            line_addr_q  <= line_addr_d;
            beat_cnt_q   <= beat_cnt_d;
            size_q       <= size_d;
            line_end_q   <= line_end_d;
            cube_end_q   <= cube_end_d;
            layer_done_q <= layer_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        line_addr_d  = line_addr_q;
        beat_cnt_d   = beat_cnt_q;
        size_d       = size_q;
        line_end_d   = line_end_q;
        cube_end_d   = cube_end_q;
        layer_done_d = 1'b0;
        cmd_prdy_c   = 1'b0;
        dat_prdy_c   = 1'b0;
        req_pvld_c   = 1'b0;
        req_type_c   = 1'b0;
        req_pd_c     = '0;

        case (state_q)
            IDLE: begin
                if (op_en) begin
                    cur_addr_d  = reg2dp_dst_base_addr;
                    line_addr_d = reg2dp_dst_base_addr;
                end else if (!rst_q) begin
                    cmd_prdy_c = 1'b1;
                    if (bus.cmd_fifo_rd_pvld) begin
                        size_d     = bus.cmd_fifo_rd_pd[SZW-1:0];
                        line_end_d = bus.cmd_fifo_rd_pd[SZW];
                        cube_end_d = bus.cmd_fifo_rd_pd[SZW+1];
                        state_d    = CMD;
                    end
                end
            end
            CMD: begin
                req_pvld_c = 1'b1;
                req_pd_c   = cmd_pd;
                if (bus.dma_wr_req_prdy) begin
                    beat_cnt_d = '0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                req_pvld_c = bus.dat_pvld;
                dat_prdy_c = bus.dma_wr_req_prdy;
                req_type_c = 1'b1;
                req_pd_c   = bus.dat_pd;
                if (bus.dat_pvld && bus.dma_wr_req_prdy) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == size_q) begin
                        state_d      = IDLE;
                        layer_done_d = cube_end_q;
                        if (line_end_q) begin
                            line_addr_d = line_addr_q + reg2dp_dst_line_stride;
                            cur_addr_d  = line_addr_q + reg2dp_dst_line_stride;
                        end else begin
                            cur_addr_d = cur_addr_q + (32'(size_q) + 32'd1) * BEAT_BYTES;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cdp_wdma_dma_req.sv
// Scoreboard bench: each command pushes its expected command/data beats; a negedge monitor pops and compares.
module tb_cdp_wdma_dma_req;
    localparam int DW  = 64;
    localparam int SZW = 13;

    typedef struct packed {
        logic          last_cube;
        logic          typ;
        logic [DW-1:0] pd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_en = 1'b0;
    logic [31:0] base = '0;
    logic [31:0] stride = '0;
    logic        layer_done;

    int   n_cmp = 0;
    int   n_err = 0;
    int   prdy_mode = 0;
    exp_t exp_q[$];

    logic [31:0] m_cur = '0;
    logic [31:0] m_line = '0;

    cdp_wdma_dma_req_if #(.DW(DW), .SZW(SZW)) bus ();

    cdp_wdma_dma_req #(.DW(DW), .SZW(SZW)) dut (
        .nvdla_core_clk         (clk),
        .nvdla_core_rst         (rst),
        .op_en                  (op_en),
        .reg2dp_dst_base_addr   (base),
        .reg2dp_dst_line_stride (stride),
        .layer_done             (layer_done),
        .bus                    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_req_pvld"}, bus.dma_wr_req_pvld, 0);
        chk({tag, "_cmd_prdy"}, bus.cmd_fifo_rd_prdy, 0);
        chk({tag, "_dat_prdy"}, bus.dat_prdy, 0);
        chk({tag, "_layer_done"}, layer_done, 0);
    endtask

    // 0: always ready, 1: random, 2: held low
    initial begin
        bus.dma_wr_req_prdy = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (prdy_mode)
                1:       bus.dma_wr_req_prdy = 1'($urandom_range(0, 1));
                2:       bus.dma_wr_req_prdy = 1'b0;
                default: bus.dma_wr_req_prdy = 1'b1;
            endcase
        end
    end

    initial begin : monitor
        logic          ld_pend = 1'b0;
        logic          ld_now;
        logic          prev_stall = 1'b0;
        logic [DW+1:0] prev_val = '0;
        exp_t          e;
        forever begin
            @(negedge clk);
            ld_now  = ld_pend;
            ld_pend = 1'b0;
            if (layer_done || ld_now)
                chk("layer_done", layer_done, ld_now);
            if (prev_stall && !rst)
                chk("stall_hold", {bus.dma_wr_req_pvld, bus.dma_wr_req_type, bus.dma_wr_req_pd}, prev_val);
            if (bus.dma_wr_req_pvld && bus.dma_wr_req_prdy) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk(e.typ ? "data_beat" : "cmd_beat",
                        {bus.dma_wr_req_type, bus.dma_wr_req_pd}, {e.typ, e.pd});
                    ld_pend = e.last_cube;
                end
            end
            prev_stall = bus.dma_wr_req_pvld && !bus.dma_wr_req_prdy;
            prev_val   = {bus.dma_wr_req_pvld, bus.dma_wr_req_type, bus.dma_wr_req_pd};
        end
    end

    task automatic start_layer(input logic [31:0] b);
        @(posedge clk); #1;
        base  = b;
        op_en = 1'b1;
        @(posedge clk); #1;
        op_en  = 1'b0;
        m_cur  = b;
        m_line = b;
    endtask

    // stall: hold DMA ready low 5 cycles in CMD (with an ignored op_en), then random data/ready gaps.
    // abort_at >= 0: reset is asserted instead of presenting that data beat.
    task automatic send_cmd(input int sz, input logic le, input logic ce,
                            input bit stall, input int abort_at);
        logic [DW-1:0] d[$];
        logic [DW-1:0] cpd;
        int            n;
        cpd          = '0;
        cpd[31:0]    = m_cur;
        cpd[32 +: SZW] = SZW'(sz);
        cpd[32 + SZW]  = ce;
        exp_q.push_back('{1'b0, 1'b0, cpd});
        for (int i = 0; i <= sz; i++) begin
            d.push_back({$urandom, $urandom});
            exp_q.push_back('{ce && (i == sz), 1'b1, d[i]});
        end
        if (le) begin
            m_line = m_line + stride;
            m_cur  = m_line;
        end else begin
            m_cur = m_cur + 32'(sz + 1) * 32'd8;
        end

        if (stall) prdy_mode = 2;
        @(posedge clk); #1;
        bus.cmd_fifo_rd_pvld = 1'b1;
        bus.cmd_fifo_rd_pd   = {ce, le, SZW'(sz)};
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.cmd_fifo_rd_prdy) break;
            if (++n > 200) begin chk("cmd_pop_timeout", 1, 0); break; end
        end
        @(posedge clk); #1;
        bus.cmd_fifo_rd_pvld = 1'b0;
        if (stall) begin
            op_en = 1'b1;
            base  = 32'hDEAD_0000;
            @(posedge clk); #1;
            op_en = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            prdy_mode = 1;
        end

        for (int i = 0; i <= sz; i++) begin
            if (i == abort_at) begin
                rst          = 1'b1;
                bus.dat_pvld = 1'b1;
                bus.dat_pd   = d[i];
                @(negedge clk);
                chk_quiet("rst_cycle");
                @(posedge clk); #1;
                rst          = 1'b0;
                bus.dat_pvld = 1'b0;
                @(negedge clk);
                chk_quiet("rst_after");
                exp_q.delete();
                m_cur  = '0;
                m_line = '0;
                return;
            end
            if (stall) begin
                bus.dat_pvld = 1'b0;
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
            bus.dat_pvld = 1'b1;
            bus.dat_pd   = d[i];
            n = 0;
            forever begin
                @(negedge clk);
                if (bus.dat_prdy && bus.dma_wr_req_prdy) break;
                if (++n > 200) begin chk("dat_timeout", 1, 0); break; end
            end
            @(posedge clk); #1;
        end
        bus.dat_pvld = 1'b0;
        prdy_mode    = 0;
    endtask

    initial begin
        bus.cmd_fifo_rd_pvld = 1'b0;
        bus.cmd_fifo_rd_pd   = '0;
        bus.dat_pvld         = 1'b0;
        bus.dat_pd           = '0;

        repeat (2) @(negedge clk);
        chk_quiet("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("post_reset");

        stride = 32'h400;
        start_layer(32'h1000);
        send_cmd(3, 1'b0, 1'b0, 1'b0, -1);
        send_cmd(0, 1'b0, 1'b0, 1'b0, -1);     // command beat shows 0x1020

        start_layer(32'h1000);
        send_cmd(1, 1'b1, 1'b0, 1'b0, -1);
        send_cmd(1, 1'b1, 1'b0, 1'b0, -1);     // 0x1000 then 0x1400
        send_cmd(0, 1'b0, 1'b1, 1'b0, -1);     // single beat, cube end

        send_cmd(7, 1'b0, 1'b1, 1'b1, -1);
        base = 32'h1000;
        send_cmd(5, 1'b1, 1'b0, 1'b1, -1);

        start_layer(32'hFFFF_FFF0);
        send_cmd(3, 1'b0, 1'b0, 1'b0, -1);
        send_cmd(0, 1'b0, 1'b0, 1'b0, -1);     // wrapped to 0x10

        start_layer(32'h3000);
        send_cmd(3, 1'b0, 1'b1, 1'b0, 2);
        repeat (3) @(posedge clk);
        start_layer(32'h2000);
        send_cmd(0, 1'b0, 1'b0, 1'b0, -1);

        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
